// File: rtl/ring_pkg.sv
// rtl/ring_pkg.sv - shared types and constants for the ring phase monitor
package ring_pkg;

    localparam int RING_WIDTH_DEF = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_TRACK = 2'd1,
        ST_ERROR = 2'd2
    } ring_state_e;

    localparam logic [1:0] ERR_NONE   = 2'b00;
    localparam logic [1:0] ERR_ONEHOT = 2'b01;
    localparam logic [1:0] ERR_SEQ    = 2'b10;

endpackage

// File: rtl/ring_onehot_chk.sv
// rtl/ring_onehot_chk.sv - combinational one-hot validity and bit index of a vector
module ring_onehot_chk
    import ring_pkg::*;
#(
    parameter int WIDTH = RING_WIDTH_DEF
) (
    input  logic [WIDTH-1:0]         vec,
    output logic                     onehot,
    output logic [$clog2(WIDTH)-1:0] idx
);

    always_comb begin
        idx = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (vec[i]) begin
                idx = i[$clog2(WIDTH)-1:0];
            end
        end
        onehot = (vec != '0) && ((vec & (vec - 1'b1)) == '0);
    end

endmodule

// File: rtl/ring_phase_monitor.sv
// rtl/ring_phase_monitor.sv - ring counter phase tracker with revolution count; RING_MON_SEQ_CHECK_EN enables sequence checking
module ring_phase_monitor
    import ring_pkg::*;
#(
    parameter int WIDTH = RING_WIDTH_DEF,
    parameter int REV_W = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [WIDTH-1:0]         phase_in,
    input  logic                     phase_vld,
    input  logic                     clr_err,
    output logic [$clog2(WIDTH)-1:0] phase_idx,
    output logic [REV_W-1:0]         rev_cnt,
    output logic                     rev_wrap,
    output logic                     err,
    output logic [1:0]               err_code
);

    localparam logic [WIDTH-1:0] LSB_ONLY = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] MSB_ONLY = {1'b1, {(WIDTH-1){1'b0}}};

    ring_state_e              state;
    logic [WIDTH-1:0]         phase_q;
    logic                     oh_valid;
    logic [$clog2(WIDTH)-1:0] oh_idx;
    logic                     is_same;
    logic                     is_succ;
    logic                     is_rev;
    logic                     seq_ok;

    ring_onehot_chk #(.WIDTH(WIDTH)) u_onehot_chk (
        .vec    (phase_in),
        .onehot (oh_valid),
        .idx    (oh_idx)
    );

    assign is_same = (phase_in == phase_q);
    assign is_succ = (phase_in == {phase_q[0], phase_q[WIDTH-1:1]});
    assign is_rev  = (phase_q == LSB_ONLY) && (phase_in == MSB_ONLY);

`ifdef RING_MON_SEQ_CHECK_EN
    assign seq_ok = is_succ;
`else
    // Any one-hot jump is tolerated; only the 0..01 -> 10..0 step counts a revolution.
    assign seq_ok = 1'b1;
    logic unused_succ;
    assign unused_succ = is_succ;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            phase_q   <= '0;
            phase_idx <= '0;
            rev_cnt   <= '0;
            rev_wrap  <= 1'b0;
            err       <= 1'b0;
            err_code  <= ERR_NONE;
        end else begin
            rev_wrap <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (phase_vld) begin
                        if (oh_valid) begin
                            phase_q   <= phase_in;
                            phase_idx <= oh_idx;
                            state     <= ST_TRACK;
                        end else begin
                            state    <= ST_ERROR;
                            err      <= 1'b1;
                            err_code <= ERR_ONEHOT;
                        end
                    end
                end
                ST_TRACK: begin
                    if (phase_vld) begin
                        if (!oh_valid) begin
                            state    <= ST_ERROR;
                            err      <= 1'b1;
                            err_code <= ERR_ONEHOT;
                        end else if (is_same) begin
                            state <= ST_TRACK;
                        end else if (seq_ok) begin
                            phase_q   <= phase_in;
                            phase_idx <= oh_idx;
                            if (is_rev) begin
                                rev_cnt  <= rev_cnt + 1'b1;
                                rev_wrap <= &rev_cnt;
                            end
                        end else begin
                            state    <= ST_ERROR;
                            err      <= 1'b1;
                            err_code <= ERR_SEQ;
                        end
                    end
                end
                ST_ERROR: begin
                    // Clear takes priority; a sample arriving alongside it is dropped.
                    if (clr_err) begin
                        state    <= ST_IDLE;
                        err      <= 1'b0;
                        err_code <= ERR_NONE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ring_phase_monitor.sv
// tb/tb_ring_phase_monitor.sv - self-checking bench for ring_phase_monitor
module tb_ring_phase_monitor;

    localparam int W  = 4;
    localparam int RW = 2;
`ifdef RING_MON_SEQ_CHECK_EN
    localparam bit SEQ = 1'b1;
`else
    localparam bit SEQ = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [W-1:0]  phase_in = '0;
    logic          phase_vld = 1'b0;
    logic          clr_err = 1'b0;
    logic [1:0]    phase_idx;
    logic [RW-1:0] rev_cnt;
    logic          rev_wrap;
    logic          err;
    logic [1:0]    err_code;

    int total = 0;
    int bad   = 0;

    // Reference model: mode 0 idle, 1 tracking, 2 error; position is a bit index.
    int m_mode = 0, m_pos = 0, m_rev = 0, m_wrap = 0, m_err = 0, m_code = 0;

    ring_phase_monitor #(.WIDTH(W), .REV_W(RW)) dut (
        .clk       (clk),
        .rst       (rst),
        .phase_in  (phase_in),
        .phase_vld (phase_vld),
        .clr_err   (clr_err),
        .phase_idx (phase_idx),
        .rev_cnt   (rev_cnt),
        .rev_wrap  (rev_wrap),
        .err       (err),
        .err_code  (err_code)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_step(input bit r, input bit vld, input logic [W-1:0] v, input bit clr);
        int n;
        int k;
        m_wrap = 0;
        if (r) begin
            m_mode = 0; m_pos = 0; m_rev = 0; m_err = 0; m_code = 0;
            return;
        end
        n = $countones(v);
        k = 0;
        for (int i = 0; i < W; i++) if (v[i]) k = i;
        case (m_mode)
            0: if (vld) begin
                if (n != 1) begin m_mode = 2; m_err = 1; m_code = 1; end
                else begin m_pos = k; m_mode = 1; end
            end
            1: if (vld) begin
                if (n != 1) begin m_mode = 2; m_err = 1; m_code = 1; end
                else if (k == m_pos) begin end
                else if (SEQ && k != (m_pos + W - 1) % W) begin m_mode = 2; m_err = 1; m_code = 2; end
                else begin
                    if (m_pos == 0 && k == W - 1) begin
                        m_rev = (m_rev + 1) % (1 << RW);
                        m_wrap = (m_rev == 0) ? 1 : 0;
                    end
                    m_pos = k;
                end
            end
            default: if (clr) begin m_mode = 0; m_err = 0; m_code = 0; end
        endcase
    endtask

    task automatic step(input string tag, input bit r, input bit vld, input logic [W-1:0] v, input bit clr);
        rst = r; phase_vld = vld; phase_in = v; clr_err = clr;
        @(posedge clk);
        #1;
        model_step(r, vld, v, clr);
        chk({tag, "_idx"},  32'(phase_idx), 32'(m_pos));
        chk({tag, "_rev"},  32'(rev_cnt),   32'(m_rev));
        chk({tag, "_wrap"}, 32'(rev_wrap),  32'(m_wrap));
        chk({tag, "_err"},  32'(err),       32'(m_err));
        chk({tag, "_code"}, 32'(err_code),  32'(m_code));
    endtask

    initial begin
        int wraps;
        int sel;
        int k;
        logic [W-1:0] v;

        // Reset overrides a simultaneous sample.
        step("rst0", 1, 1, 4'b0100, 0);
        chk("rst0_idx_c", 32'(phase_idx), 0);
        chk("rst0_err_c", 32'(err), 0);

        // One full revolution from 1000.
        step("r33a", 0, 1, 4'b1000, 0); chk("r33a_c", 32'(phase_idx), 3);
        step("r33b", 0, 1, 4'b0100, 0); chk("r33b_c", 32'(phase_idx), 2);
        step("r33c", 0, 1, 4'b0010, 0); chk("r33c_c", 32'(phase_idx), 1);
        step("r33d", 0, 1, 4'b0001, 0); chk("r33d_c", 32'(phase_idx), 0);
        step("r33e", 0, 1, 4'b1000, 0); chk("r33e_c", 32'(phase_idx), 3);
        chk("r33_rev_c", 32'(rev_cnt), 1);
        chk("r33_err_c", 32'(err), 0);

        // Repeat of the stored phase holds; idle cycles change nothing.
        step("hold", 0, 1, 4'b1000, 0);
        step("novld", 0, 0, 4'b0110, 1);
        chk("novld_wrap_c", 32'(rev_wrap), 0);

        // Jump 1000 -> 0010.
        step("r35", 0, 1, 4'b0010, 0);
`ifdef RING_MON_SEQ_CHECK_EN
        chk("r35_code_c", 32'(err_code), 2);
`else
        chk("r35_idx_c", 32'(phase_idx), 1);
        chk("r35_err_c", 32'(err), 0);
`endif

        // Non-one-hot sample from TRACK, then error-state behaviour.
        step("r34rst", 1, 0, 4'b0000, 0);
        step("r34a", 0, 1, 4'b1000, 0);
        step("r34b", 0, 1, 4'b0100, 0);
        step("r34c", 0, 1, 4'b0110, 0);
        chk("r34_err_c",  32'(err), 1);
        chk("r34_code_c", 32'(err_code), 1);
        step("r34ign", 0, 1, 4'b0010, 0);
        chk("r34_ign_idx_c", 32'(phase_idx), 2);
        step("r37", 0, 1, 4'b1000, 1);
        chk("r37_err_c", 32'(err), 0);
        chk("r37_idx_c", 32'(phase_idx), 2);
        step("clr_idle", 0, 0, 4'b0000, 1);
        // Back in IDLE, any one-hot is accepted without counting.
        step("idle_acc", 0, 1, 4'b0001, 0);
        chk("idle_acc_c", 32'(phase_idx), 0);
        chk("idle_rev_c", 32'(rev_cnt), 0);

        // Four revolutions with a 2-bit counter: wrap on the fourth.
        step("r36rst", 1, 0, 4'b0000, 0);
        step("r36s", 0, 1, 4'b1000, 0);
        wraps = 0;
        for (int r = 1; r <= 4; r++) begin
            for (int p = 2; p >= -1; p--) begin
                v = '0;
                v[(p + W) % W] = 1'b1;
                step("r36", 0, 1, v, 0);
                if (rev_wrap) wraps++;
            end
            chk("r36_rev_c", 32'(rev_cnt), 32'(r % 4));
        end
        chk("r36_wrapcnt", 32'(wraps), 1);
        step("r36post", 0, 0, 4'b0000, 0);
        chk("r36_wrapoff", 32'(rev_wrap), 0);

        // Reset mid-revolution with a sample present.
        step("r38a", 0, 1, 4'b0100, 0);
        step("r38b", 0, 1, 4'b0010, 0);
        step("r38", 1, 1, 4'b0100, 0);
        chk("r38_idx_c", 32'(phase_idx), 0);
        chk("r38_rev_c", 32'(rev_cnt), 0);

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            sel = $urandom_range(0, 99);
            k = (m_pos + W - 1) % W;
            v = '0;
            if (sel < 60) v[k] = 1'b1;
            else if (sel < 72) v[m_pos] = 1'b1;
            else if (sel < 86) v[$urandom_range(0, W - 1)] = 1'b1;
            else v = W'($urandom_range(0, (1 << W) - 1));
            step("rnd", ($urandom_range(0, 99) < 2), ($urandom_range(0, 99) < 80), v,
                 ($urandom_range(0, 99) < 15));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
